// File: rtl/led_matrix_row_expander_if.sv
// Row-write bus between the CPU side and the row expander.
// Ports: isTarget/address/data (master->slave), busy/overflow (slave->master).
interface led_matrix_row_expander_if;
  logic        isTarget;
  logic [27:0] address;
  logic [31:0] data;
  logic        busy;
  logic        overflow;

  modport master (
    output isTarget, address, data,
    input  busy, overflow
  );

  modport slave (
    input  isTarget, address, data,
    output busy, overflow
  );
endinterface

// File: rtl/led_matrix_row_expander.sv
// Expands 8-bit row writes into eight per-pixel LED matrix writes via a FIFO.
// Ports: clk, reset (sync, active-high), bus (slave: row writes, busy, overflow),
//   matrixIsTarget/matrixAddress/matrixData (registered per-pixel writes).
// Option: define LED_MATRIX_SKIP_UNCHANGED_EN to drop rows equal to the last
//   emitted value of that row (8x8 shadow, reset to zero).
module led_matrix_row_expander #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  led_matrix_row_expander_if.slave    bus,
  output logic                        matrixIsTarget,
  output logic [27:0]                 matrixAddress,
  output logic [31:0]                 matrixData
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, EMIT} state_e;

  state_e        state_q, state_d;
  logic [2:0]    col_q, col_d;
  logic [2:0]    row_q, row_d;
  logic [7:0]    bits_q, bits_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          mtgt_q, mtgt_d;
  logic [5:0]    maddr_q, maddr_d;
  logic          mbit_q, mbit_d;
  logic [10:0]   fifo_q [FIFO_DEPTH];

  logic       full, empty, push, pop;
  logic       want_pop, skip, emit_new;
  logic [2:0] head_row;
  logic [7:0] head_bits;

  logic unused_bits;
  assign unused_bits = ^{bus.address[27:5], bus.address[1:0], bus.data[31:8]};

  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  // Fullness is taken before the edge, so a pop in the same cycle
  // does not make room for the push.
  assign push      = bus.isTarget && !full;
  assign head_row  = fifo_q[rd_ptr_q][10:8];
  assign head_bits = fifo_q[rd_ptr_q][7:0];

`ifdef LED_MATRIX_SKIP_UNCHANGED_EN
  logic [7:0] shadow_q [8];
  assign skip = (head_bits == shadow_q[head_row]);
`else
  assign skip = 1'b0;
`endif

  assign bus.busy     = full;
  assign bus.overflow = ovf_q;

  assign matrixIsTarget = mtgt_q;
  assign matrixAddress  = {20'b0, maddr_q, 2'b00};
  assign matrixData     = {31'b0, mbit_q};

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    bits_d   = bits_q;
    want_pop = 1'b0;
    case (state_q)
      IDLE:    want_pop = 1'b1;
      EMIT:    want_pop = (col_q == 3'd7);
      default: want_pop = 1'b1;
    endcase
    pop      = want_pop && !empty;
    emit_new = pop && !skip;
    if (want_pop) begin
      if (emit_new) begin
        state_d = EMIT;
        col_d   = 3'd0;
        row_d   = head_row;
        bits_d  = head_bits;
      end else begin
        // Also covers a skipped row: behave as if it just finished.
        state_d = IDLE;
        col_d   = 3'd0;
      end
    end else begin
      col_d = col_q + 3'd1;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q | (bus.isTarget & full);
  end

  // Output logic: registered matrix outputs follow the next state
  always_comb begin
    mtgt_d  = (state_d == EMIT);
    maddr_d = '0;
    mbit_d  = 1'b0;
    if (mtgt_d) begin
      maddr_d = {row_d, col_d};
      mbit_d  = bits_d[col_d];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      bits_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      mtgt_q   <= 1'b0;
      maddr_q  <= '0;
      mbit_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      bits_q   <= bits_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      mtgt_q   <= mtgt_d;
      maddr_q  <= maddr_d;
      mbit_q   <= mbit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_q[wr_ptr_q] <= {bus.address[4:2], bus.data[7:0]};
    end
  end

`ifdef LED_MATRIX_SKIP_UNCHANGED_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
    end else if (emit_new) begin
      shadow_q[head_row] <= head_bits;
    end
  end
`endif

endmodule
